sdram_capture_master: RTL and testbench

Avalon-MM master that drives the SDRAM controller's `avalon_mms_*` slave port. In capture mode it accepts a valid/ready stream of 32-bit ADC sample words and writes them to consecutive SDRAM word addresses. In readback mode it reads a programmed region back out as a stream. It sits between the ADC sample packer / host readout logic and the SDRAM controller, and owns all request, waitrequest and readdatavalid handling.

---
 rtl/sdram_master_pkg.sv | 18 +
 rtl/sdram_master_fifo.sv | 44 ++++
 rtl/sdram_capture_master.sv | 171 +++++++++++++++++
 tb/tb_sdram_capture_master.sv | 510 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_master_pkg.sv
// Shared types and constants for the SDRAM capture/readback Avalon-MM master.
package sdram_master_pkg;

  localparam int unsigned ADDR_W_DEF = 24;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic MODE_CAPTURE  = 1'b0;
  localparam logic MODE_READBACK = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/sdram_master_fifo.sv
// Synchronous show-ahead FIFO buffering capture samples ahead of the SDRAM writes.
module sdram_master_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sdram_capture_master.sv
// Avalon-MM master: streams ADC samples into SDRAM (capture) or reads a region back out.
// Optional stall statistics output enabled with `define SDRAM_MASTER_STATS_EN.
module sdram_capture_master
  import sdram_master_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned MAX_PENDING = 8
) (
  input  logic              in_clk_clk,
  input  logic              in_rst_reset_n,
  input  logic              cfg_start,
  input  logic              cfg_mode,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [ADDR_W-1:0] cfg_length,
  input  logic [DATA_W-1:0] smp_data,
  input  logic              smp_valid,
  output logic              smp_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable_n,
  output logic              avm_chipselect,
  output logic [DATA_W-1:0] avm_writedata,
  output logic              avm_read_n,
  output logic              avm_write_n,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest
`ifdef SDRAM_MASTER_STATS_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int unsigned   PW    = $clog2(MAX_PENDING + 1);
  localparam logic [PW-1:0] MAX_P = PW'(MAX_PENDING);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] accepted;
  logic [PW-1:0]     pending;

  logic              start_ok;
  logic              wr_req, rd_req, wr_acc, rd_acc, rdv_ok, smp_push;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  assign start_ok = cfg_start && (state == S_IDLE);
  assign wr_acc   = wr_req && !avm_waitrequest;
  assign rd_acc   = rd_req && !avm_waitrequest;
  // Returns arriving with nothing outstanding are stray and dropped.
  assign rdv_ok   = avm_readdatavalid && (pending != '0);
  assign smp_push = smp_valid && smp_ready;

  assign avm_address      = addr_q;
  assign avm_byteenable_n = '0;

  sdram_master_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (in_clk_clk),
    .rst_n     (in_rst_reset_n),
    .push      (smp_push),
    .push_data (smp_data),
    .pop       (wr_acc),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge in_clk_clk or negedge in_rst_reset_n) begin
    if (!in_rst_reset_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cfg_start) begin
          if (cfg_length == '0)
            state_nxt = S_DONE;
          else if (cfg_mode == MODE_READBACK)
            state_nxt = S_READ;
          else
            state_nxt = S_WRITE;
        end
      end
      S_WRITE: if (wr_acc && remaining == ADDR_W'(1)) state_nxt = S_DONE;
      S_READ:  if (rd_acc && remaining == ADDR_W'(1)) state_nxt = S_DRAIN;
      S_DRAIN: if (pending == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Requests are decoded from registered state, so they stay put under waitrequest.
  always_comb begin
    wr_req         = (state == S_WRITE) && !fifo_empty;
    rd_req         = (state == S_READ) && (remaining != '0) && (pending < MAX_P);
    smp_ready      = (state == S_WRITE) && !fifo_full && (accepted < len_q);
    avm_chipselect = wr_req || rd_req;
    avm_write_n    = !wr_req;
    avm_read_n     = !rd_req;
    avm_writedata  = wr_req ? fifo_head : '0;
    busy           = (state != S_IDLE);
  end

  always_ff @(posedge in_clk_clk or negedge in_rst_reset_n) begin
    if (!in_rst_reset_n) begin
      addr_q    <= '0;
      remaining <= '0;
      len_q     <= '0;
      accepted  <= '0;
      pending   <= '0;
    end else if (start_ok) begin
      addr_q    <= cfg_base_addr;
      remaining <= cfg_length;
      len_q     <= cfg_length;
      accepted  <= '0;
      pending   <= '0;
    end else begin
      if (wr_acc || rd_acc) begin
        addr_q    <= addr_q + 1'b1;
        remaining <= remaining - 1'b1;
      end
      if (smp_push)
        accepted <= accepted + 1'b1;
      case ({rd_acc, rdv_ok})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase
    end
  end

  // done trails the DONE state by a cycle so busy has already dropped with it.
  always_ff @(posedge in_clk_clk or negedge in_rst_reset_n) begin
    if (!in_rst_reset_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      done     <= 1'b0;
    end else begin
      rd_valid <= rdv_ok;
      if (rdv_ok)
        rd_data <= avm_readdata;
      done <= (state == S_DONE);
    end
  end

`ifdef SDRAM_MASTER_STATS_EN
  always_ff @(posedge in_clk_clk or negedge in_rst_reset_n) begin
    if (!in_rst_reset_n)
      stall_cycles <= '0;
    else if (start_ok)
      stall_cycles <= '0;
    else if (avm_chipselect && avm_waitrequest && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 1'b1;
  end
`endif

endmodule

// File: tb/tb_sdram_capture_master.sv
// Scoreboard bench for sdram_capture_master with a behavioural Avalon slave.
module tb_sdram_capture_master;
  import sdram_master_pkg::*;

  localparam int unsigned AW   = 24;
  localparam int unsigned DW   = 32;
  localparam int unsigned DEP  = 16;
  localparam int unsigned MAXP = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic          cfg_mode = 1'b0;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [AW-1:0] cfg_length = '0;
  logic [DW-1:0] smp_data = '0;
  logic          smp_valid = 1'b0;
  logic          smp_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid, busy, done;
  logic [AW-1:0] avm_address;
  logic [3:0]    avm_byteenable_n;
  logic          avm_chipselect, avm_read_n, avm_write_n;
  logic [DW-1:0] avm_writedata;
  logic [DW-1:0] avm_readdata = '0;
  logic          avm_readdatavalid = 1'b0;
  logic          avm_waitrequest = 1'b0;
`ifdef SDRAM_MASTER_STATS_EN
  logic [31:0]   stall_cycles;
`endif

  sdram_capture_master #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .FIFO_DEPTH  (DEP),
    .MAX_PENDING (MAXP)
  ) dut (
    .in_clk_clk        (clk),
    .in_rst_reset_n    (rst_n),
    .cfg_start         (cfg_start),
    .cfg_mode          (cfg_mode),
    .cfg_base_addr     (cfg_base_addr),
    .cfg_length        (cfg_length),
    .smp_data          (smp_data),
    .smp_valid         (smp_valid),
    .smp_ready         (smp_ready),
    .rd_data           (rd_data),
    .rd_valid          (rd_valid),
    .busy              (busy),
    .done              (done),
    .avm_address       (avm_address),
    .avm_byteenable_n  (avm_byteenable_n),
    .avm_chipselect    (avm_chipselect),
    .avm_writedata     (avm_writedata),
    .avm_read_n        (avm_read_n),
    .avm_write_n       (avm_write_n),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_waitrequest   (avm_waitrequest)
`ifdef SDRAM_MASTER_STATS_EN
    ,
    .stall_cycles      (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;
  typedef struct {int due; logic [DW-1:0] data;} resp_t;

  wr_t           exp_wr[$];
  resp_t         resp_q[$];
  logic [DW-1:0] exp_rd[$];
  resp_t         r;
  wr_t           w;
  logic [DW-1:0] e;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  bit force_wait = 0;
  int stall_idx = -1;
  int stall_left = 0;
  int wr_accepts = 0;
  int stalled_writes = 0;
  int rd_accepts = 0;
  int rd_seen = 0;
  int rd_delay = 3;
  int outstanding = 0;
  int max_out = 0;
  int cs_cycles = 0;
  int sent = 0;
  bit stray_rdv = 0;
  bit rdv_model = 0;
  bit rdv_prev = 0;
  logic [AW-1:0] feed_addr = '0;
  logic [AW-1:0] exp_rd_addr = '0;

  function automatic logic [DW-1:0] rdata(input logic [AW-1:0] a);
    return {8'hD0, a} ^ 32'h0000_5A5A;
  endfunction

  always @(posedge clk) cyc++;

  // Slave: waitrequest policy and delayed read returns, driven just after the edge.
  always @(posedge clk) begin
    #1;
    avm_waitrequest = 1'b0;
    if (force_wait)
      avm_waitrequest = 1'b1;
    else if (stall_left > 0 && wr_accepts == stall_idx && avm_chipselect && !avm_write_n) begin
      avm_waitrequest = 1'b1;
      stall_left--;
    end
    rdv_model = 1'b0;
    avm_readdatavalid = stray_rdv;
    avm_readdata = $urandom;
    if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
      r = resp_q.pop_front();
      avm_readdatavalid = 1'b1;
      avm_readdata = r.data;
      exp_rd.push_back(r.data);
      outstanding--;
      rdv_model = 1'b1;
    end
  end

  // Monitor: bus requests and readback stream checked mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (avm_chipselect) begin
        cs_cycles++;
        n_cmp++;
        if ((avm_read_n ^ avm_write_n) !== 1'b1 || avm_byteenable_n !== 4'h0) begin
          n_bad++;
          $display("FAIL req_encoding: read_n=%b write_n=%b be_n=%h required exactly one active, be_n=0",
                   avm_read_n, avm_write_n, avm_byteenable_n);
        end
      end
      if (avm_chipselect && !avm_write_n) begin
        n_cmp++;
        if (exp_wr.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: addr=%h data=%h with nothing expected", avm_address, avm_writedata);
        end else if (avm_address !== exp_wr[0].addr || avm_writedata !== exp_wr[0].data) begin
          n_bad++;
          $display("FAIL write: got addr=%h data=%h required addr=%h data=%h",
                   avm_address, avm_writedata, exp_wr[0].addr, exp_wr[0].data);
        end
        if (avm_waitrequest)
          stalled_writes++;
        else if (exp_wr.size() > 0) begin
          w = exp_wr.pop_front();
          wr_accepts++;
        end
      end
      if (avm_chipselect && !avm_read_n) begin
        n_cmp++;
        if (avm_address !== exp_rd_addr) begin
          n_bad++;
          $display("FAIL read_addr: got %h required %h", avm_address, exp_rd_addr);
        end
        if (!avm_waitrequest) begin
          exp_rd_addr++;
          outstanding++;
          rd_accepts++;
          if (outstanding > max_out) max_out = outstanding;
          n_cmp++;
          if (outstanding > MAXP) begin
            n_bad++;
            $display("FAIL pending_limit: got %0d outstanding required <= %0d", outstanding, MAXP);
          end
          resp_q.push_back('{cyc + rd_delay, rdata(avm_address)});
        end
      end
      if (rd_valid || rdv_prev) begin
        n_cmp++;
        if (rd_valid !== rdv_prev) begin
          n_bad++;
          $display("FAIL rd_valid_timing: got %b required %b", rd_valid, rdv_prev);
        end
      end
      if (rd_valid) begin
        rd_seen++;
        n_cmp++;
        if (exp_rd.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_rd_valid: rd_data=%h with nothing expected", rd_data);
        end else begin
          e = exp_rd.pop_front();
          if (rd_data !== e) begin
            n_bad++;
            $display("FAIL rd_data: got %h required %h", rd_data, e);
          end
        end
      end
    end
    rdv_prev = rst_n ? rdv_model : 1'b0;
  end

  task automatic start(input logic mode, input logic [AW-1:0] base, input logic [AW-1:0] len);
    @(negedge clk);
    cfg_start = 1'b1;
    cfg_mode = mode;
    cfg_base_addr = base;
    cfg_length = len;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic feed(input int n, input logic [DW-1:0] seed, input int budget);
    int i;
    int t;
    i = 0;
    t = 0;
    while (i < n && t < budget) begin
      @(negedge clk);
      smp_valid = 1'b1;
      smp_data = seed + DW'(i);
      if (smp_ready) begin
        exp_wr.push_back('{feed_addr, seed + DW'(i)});
        feed_addr++;
        i++;
        sent++;
      end
      t++;
    end
    @(posedge clk);
    #1;
    smp_valid = 1'b0;
    n_cmp++;
    if (i != n) begin
      n_bad++;
      $display("FAIL feed_timeout: got %0d samples accepted required %0d", i, n);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int t;
    t = 0;
    while (done !== 1'b1 && t < budget) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_done_timeout: got done=%b required 1 within %0d cycles", name, done, budget);
    end else begin
      n_cmp++;
      if (busy !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_busy_at_done: got %b required 0", name, busy);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_done_pulse: got %b required 0", name, done);
      end
    end
  endtask

  task automatic test_reset();
    logic [94:0] act;
    #3;
    act = {avm_chipselect, avm_read_n, avm_write_n, avm_address, avm_writedata,
           smp_ready, rd_valid, rd_data, busy, done};
    n_cmp++;
    if (act !== {1'b0, 1'b1, 1'b1, 24'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_values: got %h required cs=0 rd_n=1 wr_n=1 others 0", act);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    outstanding = 0;
  endtask

  task automatic test_capture_basic();
    int a0;
    a0 = wr_accepts;
    feed_addr = 24'h000100;
    start(MODE_CAPTURE, 24'h000100, 24'd4);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_rise: got %b required 1", busy);
    end
    feed(4, 32'h0000_00A0, 20);
    wait_done("capture_basic", 20);
    n_cmp++;
    if (wr_accepts - a0 != 4 || exp_wr.size() != 0) begin
      n_bad++;
      $display("FAIL capture_count: got %0d writes, %0d left required 4 and 0", wr_accepts - a0, exp_wr.size());
    end
  endtask

  task automatic test_capture_stall();
    wr_accepts = 0;
    stalled_writes = 0;
    stall_idx = 1;
    stall_left = 5;
    feed_addr = 24'h000100;
    start(MODE_CAPTURE, 24'h000100, 24'd8);
    feed(8, 32'h0000_00A0, 40);
    wait_done("capture_stall", 40);
    n_cmp++;
    if (stalled_writes != 5 || wr_accepts != 8 || exp_wr.size() != 0) begin
      n_bad++;
      $display("FAIL capture_stall: got stalled=%0d writes=%0d left=%0d required 5 8 0",
               stalled_writes, wr_accepts, exp_wr.size());
    end
    stall_idx = -1;
  endtask

  task automatic test_fifo_full();
    sent = 0;
    force_wait = 1;
    feed_addr = 24'h000200;
    start(MODE_CAPTURE, 24'h000200, 24'd20);
    fork
      feed(20, 32'h1234_0000, 200);
      begin
        repeat (25) @(negedge clk);
        n_cmp++;
        if (sent != DEP || smp_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL fifo_full: got sent=%0d smp_ready=%b required %0d and 0", sent, smp_ready, DEP);
        end
        force_wait = 0;
      end
    join
    wait_done("fifo_full", 40);
    n_cmp++;
    if (exp_wr.size() != 0) begin
      n_bad++;
      $display("FAIL fifo_full_lost: got %0d unwritten required 0", exp_wr.size());
    end
  endtask

  task automatic run_readback(input string name, input logic [AW-1:0] base, input int len, input int dly);
    rd_delay = dly;
    rd_accepts = 0;
    rd_seen = 0;
    max_out = 0;
    exp_rd_addr = base;
    start(MODE_READBACK, base, AW'(len));
    n_cmp++;
    if (avm_chipselect !== 1'b1 || avm_read_n !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_first_req: got cs=%b read_n=%b required 1 0", name, avm_chipselect, avm_read_n);
    end
    wait_done(name, 600);
    n_cmp++;
    if (rd_seen != len || rd_accepts != len || exp_rd.size() != 0 || resp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_count: got rd_valid=%0d accepts=%0d required %0d", name, rd_seen, rd_accepts, len);
    end
  endtask

  task automatic test_readback();
    run_readback("readback", 24'h000300, 20, 3);
  endtask

  task automatic test_readback_window();
    run_readback("readback_window", 24'h000400, 20, 16);
    n_cmp++;
    if (max_out != MAXP) begin
      n_bad++;
      $display("FAIL pending_window: got max %0d outstanding required %0d", max_out, MAXP);
    end
  endtask

  task automatic test_wrap();
    feed_addr = 24'hFFFFFE;
    start(MODE_CAPTURE, 24'hFFFFFE, 24'd4);
    feed(4, 32'hCAFE_0000, 20);
    wait_done("wrap_capture", 20);
    run_readback("wrap_read", 24'hFFFFFE, 4, 3);
  endtask

  task automatic test_len_zero();
    int cs0;
    cs0 = cs_cycles;
    start(MODE_CAPTURE, 24'h000500, 24'd0);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL len0_early: got done=%b required 0 one cycle after start", done);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL len0_done: got done=%b required 1 two cycles after start", done);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || cs_cycles != cs0) begin
      n_bad++;
      $display("FAIL len0_quiet: got done=%b cs_cycles=%0d required 0 and %0d", done, cs_cycles, cs0);
    end
  endtask

  task automatic test_start_while_busy();
    int a0;
    int r0;
    a0 = wr_accepts;
    r0 = rd_accepts;
    feed_addr = 24'h000600;
    start(MODE_CAPTURE, 24'h000600, 24'd4);
    feed(2, 32'hBEEF_0000, 20);
    start(MODE_READBACK, 24'h000700, 24'd4);
    feed_addr = feed_addr;
    feed(2, 32'hBEEF_0002, 20);
    wait_done("busy_start", 20);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (wr_accepts - a0 != 4 || rd_accepts != r0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL start_ignored: got writes=%0d reads=%0d busy=%b required 4 0 0",
               wr_accepts - a0, rd_accepts - r0, busy);
    end
  endtask

  task automatic test_stray_rdv();
    int s0;
    s0 = rd_seen;
    @(negedge clk);
    stray_rdv = 1;
    @(negedge clk);
    stray_rdv = 0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (rd_seen != s0 || rd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stray_rdv: got %0d rd_valid pulses required 0", rd_seen - s0);
    end
  endtask

  task automatic test_reset_mid();
    logic [94:0] act;
    force_wait = 1;
    feed_addr = 24'h000800;
    start(MODE_CAPTURE, 24'h000800, 24'd8);
    feed(3, 32'h7777_0000, 20);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_busy: got %b required 1", busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    act = {avm_chipselect, avm_read_n, avm_write_n, avm_address, avm_writedata,
           smp_ready, rd_valid, rd_data, busy, done};
    n_cmp++;
    if (act !== {1'b0, 1'b1, 1'b1, 24'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_async: got %h required cs=0 rd_n=1 wr_n=1 others 0", act);
    end
    exp_wr.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    force_wait = 0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_no_done: got done=%b busy=%b required 0 0", done, busy);
      end
    end
    feed_addr = 24'h000900;
    start(MODE_CAPTURE, 24'h000900, 24'd5);
    feed(5, 32'h5555_0000, 30);
    wait_done("after_reset", 30);
    n_cmp++;
    if (exp_wr.size() != 0) begin
      n_bad++;
      $display("FAIL after_reset_lost: got %0d unwritten required 0", exp_wr.size());
    end
  endtask

  initial begin
    test_reset();
    test_capture_basic();
    test_capture_stall();
    test_fifo_full();
    test_readback();
    test_readback_window();
    test_wrap();
    test_len_zero();
    test_start_while_busy();
    test_stray_rdv();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

endmodule
